cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
- Hardware trace capture for the accumulator CPU. Replaces the per-cycle text dump of CPU state with on-chip capture.
- Records {pc, instr, acc, ctrl} snapshots into a parametrised ring buffer around a PC-match trigger (pre- and post-trigger history).
- Drains the captured window oldest-first over a valid/ready read port to a debug/UART host.
- Sits beside the cpu top level and taps its internal state each clock.

Parameters:
- PC_W, 8, program counter width
- INSTR_W, 8, instruction width
- DATA_W, 8, accumulator width
- CTRL_W, 8, packed control bits {alu_en, alu_op[2:0], mem_read, mem_write, acc_write, use_immed}
- DEPTH, 16, entries; power of two, >= 4
- TS_W, 16, timestamp width; used only with TRACE_TIMESTAMP_EN

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous active-low reset
- arm, in, 1, one-cycle pulse: clear buffer and start capture
- trig_en, in, 1, 1 = wait for PC match; 0 = trigger on first valid sample
- trig_pc, in, PC_W, trigger PC value
- post_count, in, $clog2(DEPTH), entries to record after the trigger entry
- cap_valid, in, 1, sample strobe (CPU advanced this cycle)
- cap_pc, in, PC_W, sampled PC
- cap_instr, in, INSTR_W, sampled instruction
- cap_acc, in, DATA_W, sampled accumulator
- cap_ctrl, in, CTRL_W, sampled control bits
- rd_valid, out, 1, rd_data holds an entry
- rd_ready, in, 1, host accepts the entry
- rd_data, out, ENTRY_W, packed entry {pc, instr, acc, ctrl}, pc in the MSBs
- rd_last, out, 1, final entry of the window
- state, out, 2, IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- count, out, $clog2(DEPTH)+1, entries held
- overflow, out, 1, pre-trigger history was overwritten

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, wr_ptr=rd_ptr=0, count=0, overflow=0, rd_valid=0, rd_last=0, rd_data=0. Reset has priority over every other input, including mid-capture and mid-readout.
- arm has priority over all non-reset events in every state. It clears pointers, count and overflow, drops rd_valid, and sets state=ARMED. post_count, trig_en and trig_pc are latched at arm.
- ARMED:
  - Each cap_valid writes an entry.
  - If the buffer is full, the oldest entry is overwritten, rd_ptr advances, count stays at DEPTH, and overflow=1.
  - Trigger = cap_valid && (!trig_en || cap_pc==trig_pc). The trigger sample is written, and the post counter is loaded with post_count.
  - If post_count==0 the next state is DONE; otherwise CAPTURE.
- CAPTURE:
  - Each cap_valid writes an entry (same overwrite rule) and decrements the post counter.
  - When the post counter reaches 0 on a write, the next state is DONE.
  - post_count <= DEPTH-1 by width, so post-trigger data is never overwritten.
- DONE:
  - cap_valid is ignored.
  - One cycle after entering DONE, rd_valid=1 with rd_data set to the oldest entry.
  - Pop occurs on rd_valid && rd_ready. rd_ptr increments mod DEPTH, count decrements, and the next entry is presented on the following cycle. Back-to-back pops give one entry per cycle.
  - rd_data and rd_last are held stable while rd_valid && !rd_ready.
  - rd_last=1 exactly when count==1.
  - On popping the last entry: rd_valid=0, state=IDLE. overflow is held until the next arm or reset.
- IDLE: cap_valid and rd_ready are ignored.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - A TS_W free-running cycle counter runs, reset to 0 and wrapping at 2**TS_W.
  - Its value at the capture cycle is appended as the LSBs of each entry, and ENTRY_W grows by TS_W.
  - The counter clears on arm.
- TRACE_TIMESTAMP_EN undefined: no counter, no timestamp field, and ENTRY_W = PC_W+INSTR_W+DATA_W+CTRL_W.

Decomposition:
- Package cpu_trace_pkg: state encoding constants, ctrl bit positions (ALU_EN_BIT=7, ALU_OP_MSB=6, ALU_OP_LSB=4, MEM_READ_BIT=3, MEM_WRITE_BIT=2, ACC_WRITE_BIT=1, USE_IMMED_BIT=0), and a field-offset function deriving ENTRY_W.
- Sub-module trace_ram: DEPTH x ENTRY_W simple dual-port storage with synchronous write and registered read. The top level holds the FSM, pointers and counters.

Test Plan (DEPTH=8 unless stated):
- Reset held for 2 cycles mid-CAPTURE -> state=0, count=0, rd_valid=0, overflow=0 on the first edge after release.
- trig_en=0, post_count=3, arm, cap_valid continuous with pc=0..5 -> DONE after pc 3; readout is pc 0,1,2,3 with rd_last on pc 3; state returns to 0.
- trig_en=1, trig_pc=10, post_count=2, pc=0..12 continuous -> count=8, overflow=1; readout is pc 5..12, and pc 10 is the 6th entry.
- DONE with 4 entries, rd_ready pattern 1,0,0,1,1,0,1 -> exactly 4 pops, rd_data stable during stalls, no duplicate or dropped entries.
- arm pulsed in CAPTURE after 5 writes -> next cycle state=1, count=0, overflow=0, and the old data is never read out.
- With TRACE_TIMESTAMP_EN: arm, then samples at cycles 2, 3 and 7 after arm -> timestamps 2, 3, 7 in the entry LSBs.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared state encoding, ctrl bit positions and entry width for the CPU trace buffer
// Build option: TRACE_TIMESTAMP_EN appends a TS_W timestamp to each entry.
package cpu_trace_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    localparam int ALU_EN_BIT    = 7;
    localparam int ALU_OP_MSB    = 6;
    localparam int ALU_OP_LSB    = 4;
    localparam int MEM_READ_BIT  = 3;
    localparam int MEM_WRITE_BIT = 2;
    localparam int ACC_WRITE_BIT = 1;
    localparam int USE_IMMED_BIT = 0;

    // Entry is {pc, instr, acc, ctrl[, ts]} with pc in the MSBs.
    function automatic int entry_width(input int pc_w, input int instr_w, input int data_w,
                                       input int ctrl_w, input int ts_w);
`ifdef TRACE_TIMESTAMP_EN
        return pc_w + instr_w + data_w + ctrl_w + ts_w;
`else
        return pc_w + instr_w + data_w + ctrl_w + 0 * ts_w;
`endif
    endfunction

    // LSB position of the pc field inside an entry.
    function automatic int pc_offset(input int entry_w, input int pc_w);
        return entry_w - pc_w;
    endfunction
endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// trace_ram: DEPTH x WIDTH simple dual-port storage, synchronous write, registered read
// Ports: clk; we/waddr/wdata write port; raddr in, rdata registered out.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: PC-triggered ring-buffer capture of CPU state with valid/ready oldest-first readout
// Ports: clk, reset (sync, active-low); arm/trig_en/trig_pc/post_count control;
//        cap_valid/cap_pc/cap_instr/cap_acc/cap_ctrl sample tap;
//        rd_valid/rd_ready/rd_data/rd_last read port; state, count, overflow status.
// Build option: TRACE_TIMESTAMP_EN adds a free-running timestamp in the entry LSBs.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8,
    parameter int DATA_W  = 8,
    parameter int CTRL_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 16,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int ENTRY_W = entry_width(PC_W, INSTR_W, DATA_W, CTRL_W, TS_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic [PTR_W-1:0]   post_count,
    input  logic               cap_valid,
    input  logic [PC_W-1:0]    cap_pc,
    input  logic [INSTR_W-1:0] cap_instr,
    input  logic [DATA_W-1:0]  cap_acc,
    input  logic [CTRL_W-1:0]  cap_ctrl,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_last,
    output logic [1:0]         state,
    output logic [PTR_W:0]     count,
    output logic               overflow
);
    trace_state_t cur, nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, raddr, post_cnt, post_lat;
    logic [PC_W-1:0] trig_pc_lat;
    logic trig_en_lat, we, pop, hit, full, last;
    logic [ENTRY_W-1:0] wdata, rdata;

    assign hit   = cap_valid && (!trig_en_lat || cap_pc == trig_pc_lat);
    assign full  = count == (PTR_W+1)'(DEPTH);
    assign last  = count == (PTR_W+1)'(1);
    assign state = cur;

    always_ff @(posedge clk) begin
        cur <= !reset ? IDLE : nxt;
    end

    always_comb begin
        nxt = cur;
        if (arm) nxt = ARMED;
        else begin
            case (cur)
                ARMED:   if (hit) nxt = post_lat == '0 ? DONE : CAPTURE;
                CAPTURE: if (cap_valid && post_cnt == PTR_W'(1)) nxt = DONE;
                DONE:    if (pop && last) nxt = IDLE;
                default: nxt = cur;
            endcase
        end
    end

    // Reading ahead on a pop keeps back-to-back pops at one entry per cycle.
    always_comb begin
        we    = !arm && cap_valid && (cur == ARMED || cur == CAPTURE);
        pop   = !arm && cur == DONE && rd_valid && rd_ready;
        raddr = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            rd_valid    <= 1'b0;
            post_cnt    <= '0;
            post_lat    <= '0;
            trig_en_lat <= 1'b0;
            trig_pc_lat <= '0;
        end else if (arm) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            rd_valid    <= 1'b0;
            post_lat    <= post_count;
            trig_en_lat <= trig_en;
            trig_pc_lat <= trig_pc;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (full) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    overflow <= 1'b1;
                end else count <= count + (PTR_W+1)'(1);
            end
            if (cur == ARMED && hit) post_cnt <= post_lat;
            else if (cur == CAPTURE && we) post_cnt <= post_cnt - PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                count  <= count - (PTR_W+1)'(1);
            end
            rd_valid <= cur == DONE && (pop ? !last : count != '0);
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    always_ff @(posedge clk) begin
        ts <= (!reset || arm) ? '0 : ts + TS_W'(1);
    end
    assign wdata = {cap_pc, cap_instr, cap_acc, cap_ctrl, ts};
`else
    assign wdata = {cap_pc, cap_instr, cap_acc, cap_ctrl};
`endif

    assign rd_data = rd_valid ? rdata : '0;
    assign rd_last = rd_valid && last;

    trace_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: scoreboard bench for cpu_trace_buffer at DEPTH=8
module tb_cpu_trace_buffer;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = 48;
`else
    localparam int EW = 32;
`endif
    logic clk = 0, reset = 0, arm = 0, trig_en = 0, cap_valid = 0, rd_ready = 0;
    logic [7:0] trig_pc = 0, cap_pc = 0, cap_instr = 0, cap_acc = 0, cap_ctrl = 0;
    logic [2:0] post_count = 0;
    logic rd_valid, rd_last, overflow;
    logic [EW-1:0] rd_data;
    logic [1:0] state;
    logic [3:0] count;
    logic [EW-1:0] q[$];
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .post_count(post_count), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_instr(cap_instr), .cap_acc(cap_acc), .cap_ctrl(cap_ctrl),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .state(state), .count(count), .overflow(overflow)
    );

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] tb_ts = 0;
    always @(posedge clk) tb_ts <= (!reset || arm) ? 16'd0 : tb_ts + 16'd1;
`endif

    // Tasks are entered and left at a falling edge.
    task automatic sample(input logic [7:0] pc, input bit keep);
        cap_valid = 1;
        cap_pc    = pc;
        cap_instr = pc ^ 8'h5a;
        cap_acc   = pc + 8'd3;
        cap_ctrl  = ~pc;
`ifdef TRACE_TIMESTAMP_EN
        if (keep) q.push_back({pc, pc ^ 8'h5a, 8'(pc + 8'd3), ~pc, tb_ts});
`else
        if (keep) q.push_back({pc, pc ^ 8'h5a, 8'(pc + 8'd3), ~pc});
`endif
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cap_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic arm_it(input logic te, input logic [7:0] tpc, input logic [2:0] post);
        cap_valid = 0;
        arm = 1; trig_en = te; trig_pc = tpc; post_count = post;
        @(negedge clk);
        arm = 0;
    endtask

    task automatic drain(input logic [15:0] pat, input int plen, input string name);
        int k = 0;
        int cyc = 0;
        logic [EW-1:0] held = '0;
        bit stalled = 0;
        while (q.size() > 0 && cyc < 64) begin
            if (rd_valid) begin
                vectors++;
                if (rd_data !== q[0]) begin
                    errors++; $display("FAIL %s data: got %h want %h", name, rd_data, q[0]);
                end
                vectors++;
                if (rd_last !== (q.size() == 1)) begin
                    errors++; $display("FAIL %s last: got %b want %b", name, rd_last, q.size() == 1);
                end
                if (stalled) begin
                    vectors++;
                    if (rd_data !== held) begin
                        errors++; $display("FAIL %s stall: got %h want %h", name, rd_data, held);
                    end
                end
                rd_ready = (k < plen) ? pat[k] : 1'b1;
                k++;
                stalled = !rd_ready;
                held = rd_data;
                if (rd_ready) void'(q.pop_front());
            end else rd_ready = 0;
            @(negedge clk);
            cyc++;
        end
        rd_ready = 0;
        vectors++;
        if (q.size() != 0) begin
            errors++; $display("FAIL %s timeout: %0d entries unread want 0", name, q.size());
            q.delete();
        end
        vectors++;
        if (rd_valid !== 1'b0 || state !== 2'd0) begin
            errors++; $display("FAIL %s end: got valid=%b state=%0d want valid=0 state=0", name, rd_valid, state);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        vectors++;
        if ({state, count, rd_valid, overflow, rd_last} !== 9'd0 || rd_data !== '0) begin
            errors++; $display("FAIL reset: got state=%0d count=%0d valid=%b ovf=%b last=%b data=%h want all 0",
                               state, count, rd_valid, overflow, rd_last, rd_data);
        end
    endtask

    task automatic test_free_trigger;
        arm_it(0, 8'd0, 3'd3);
        for (int p = 0; p < 6; p++) sample(8'(p), p < 4);
        cap_valid = 0;
        vectors++;
        if (state !== 2'd3 || count !== 4'd4) begin
            errors++; $display("FAIL free_trig: got state=%0d count=%0d want 3 4", state, count);
        end
        drain(16'hffff, 0, "free_trig");
    endtask

    task automatic test_overflow;
        arm_it(1, 8'd10, 3'd2);
        for (int p = 0; p < 13; p++) sample(8'(p), p >= 5);
        idle(1);
        vectors++;
        if (state !== 2'd3 || count !== 4'd8 || overflow !== 1'b1) begin
            errors++; $display("FAIL overflow: got state=%0d count=%0d ovf=%b want 3 8 1", state, count, overflow);
        end
        drain(16'hffff, 0, "overflow");
        vectors++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_held: got %b want 1", overflow);
        end
    endtask

    task automatic test_stall;
        arm_it(0, 8'd0, 3'd3);
        for (int p = 20; p < 24; p++) sample(8'(p), 1);
        idle(1);
        drain(16'b1011001, 7, "stall");
    endtask

    task automatic test_rearm;
        arm_it(1, 8'd62, 3'd5);
        for (int p = 60; p < 65; p++) sample(8'(p), 0);
        cap_valid = 0;
        vectors++;
        if (state !== 2'd2 || count !== 4'd5) begin
            errors++; $display("FAIL rearm_pre: got state=%0d count=%0d want 2 5", state, count);
        end
        arm_it(0, 8'd0, 3'd1);
        vectors++;
        if (state !== 2'd1 || count !== 4'd0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL rearm: got state=%0d count=%0d ovf=%b valid=%b want 1 0 0 0",
                               state, count, overflow, rd_valid);
        end
        sample(8'd100, 1);
        sample(8'd101, 1);
        idle(1);
        drain(16'hffff, 0, "rearm");
    endtask

    task automatic test_reset_mid;
        arm_it(0, 8'd0, 3'd6);
        for (int p = 0; p < 3; p++) sample(8'(p), 0);
        cap_valid = 0;
        vectors++;
        if (state !== 2'd2) begin
            errors++; $display("FAIL reset_mid_pre: got state=%0d want 2", state);
        end
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        vectors++;
        if (state !== 2'd0 || count !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got state=%0d count=%0d valid=%b ovf=%b want 0 0 0 0",
                               state, count, rd_valid, overflow);
        end
        sample(8'd9, 0);
        idle(1);
        vectors++;
        if (state !== 2'd0 || count !== 4'd0) begin
            errors++; $display("FAIL idle_ignore: got state=%0d count=%0d want 0 0", state, count);
        end
    endtask

    task automatic test_back_to_back;
        arm_it(0, 8'd0, 3'd7);
        for (int p = 30; p < 40; p++) sample(8'(p), p < 38);
        cap_valid = 0;
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
            errors++; $display("FAIL full_post: got count=%0d ovf=%b want 8 0", count, overflow);
        end
        drain(16'hffff, 0, "back_to_back");
        arm_it(0, 8'd0, 3'd0);
        sample(8'd40, 1);
        sample(8'd41, 0);
        cap_valid = 0;
        vectors++;
        if (count !== 4'd1 || state !== 2'd3) begin
            errors++; $display("FAIL post_zero: got count=%0d state=%0d want 1 3", count, state);
        end
        drain(16'hffff, 0, "post_zero");
    endtask

`ifdef TRACE_TIMESTAMP_EN
    task automatic test_timestamp;
        arm_it(1, 8'd77, 3'd0);
        for (int k = 0; k < 8; k++) begin
            if (k == 2 || k == 3 || k == 7) sample(k == 7 ? 8'd77 : 8'(70 + k), 1);
            else idle(1);
        end
        idle(1);
        vectors++;
        if (q.size() != 3 || q[0][15:0] !== 16'd2 || q[1][15:0] !== 16'd3 || q[2][15:0] !== 16'd7) begin
            errors++; $display("FAIL ts_model: got %0d entries want ts 2,3,7", q.size());
        end
        drain(16'hffff, 0, "timestamp");
    endtask
`endif

    initial begin
        test_reset;
        test_free_trigger;
        test_overflow;
        test_stall;
        test_rearm;
        test_reset_mid;
        test_back_to_back;
`ifdef TRACE_TIMESTAMP_EN
        test_timestamp;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
